jtag_strap_mux: RTL and testbench



---
 rtl/jtag_strap_mux.sv | 170 +++++++++++++++++
 tb/tb_jtag_strap_mux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_strap_mux.sv
// Strap-sampled JTAG pad mux: filters a strap field, locks a mode and routes one
// shared JTAG pad group to one of NumTaps TAPs. Optional SRST pad: JTAG_STRAP_MUX_SRST_EN.
module jtag_strap_mux #(
  parameter int NumIOs       = 47,
  parameter int NumTaps      = 3,
  parameter int StrapWidth   = 2,
  parameter int StrapLsbIdx  = 16,
  parameter int FilterCycles = 4,
  parameter logic [NumIOs-1:0] TieOffValues = '0,
  parameter int TckIdx       = 0,
  parameter int TmsIdx       = 1,
  parameter int TdiIdx       = 2,
  parameter int TdoIdx       = 3,
  parameter int TrstIdx      = 4
`ifdef JTAG_STRAP_MUX_SRST_EN
  ,
  parameter int SrstIdx      = 19
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lock_i,
  input  logic                  resample_i,
  output logic [StrapWidth-1:0] mode_o,
  output logic                  mode_valid_o,
  output logic [NumTaps-1:0]    tap_tck_o,
  output logic [NumTaps-1:0]    tap_tms_o,
  output logic [NumTaps-1:0]    tap_tdi_o,
  output logic [NumTaps-1:0]    tap_trst_no,
  input  logic [NumTaps-1:0]    tap_tdo_i,
  input  logic [NumIOs-1:0]     out_core_i,
  input  logic [NumIOs-1:0]     oe_core_i,
  output logic [NumIOs-1:0]     in_core_o,
  output logic [NumIOs-1:0]     out_padring_o,
  output logic [NumIOs-1:0]     oe_padring_o,
  input  logic [NumIOs-1:0]     in_padring_i
`ifdef JTAG_STRAP_MUX_SRST_EN
  ,
  output logic                  jtag_srst_no
`endif
);

  localparam int CntW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
  localparam logic [CntW-1:0]       CntMax  = CntW'(FilterCycles - 1);
  localparam logic [StrapWidth-1:0] MaxMode = StrapWidth'(NumTaps);

  // Pads taken away from the core while a TAP is selected (TDO is handled separately).
  localparam logic [NumIOs-1:0] ClaimBase = (NumIOs'(1) << TckIdx) | (NumIOs'(1) << TmsIdx) |
                                            (NumIOs'(1) << TdiIdx) | (NumIOs'(1) << TrstIdx) |
                                            (NumIOs'({StrapWidth{1'b1}}) << StrapLsbIdx);
`ifdef JTAG_STRAP_MUX_SRST_EN
  localparam logic [NumIOs-1:0] ClaimMask = ClaimBase | (NumIOs'(1) << SrstIdx);
`else
  localparam logic [NumIOs-1:0] ClaimMask = ClaimBase;
`endif
  localparam logic [NumIOs-1:0] TdoMask = NumIOs'(1) << TdoIdx;
  localparam logic [NumIOs-1:0] AllMask = ClaimMask | TdoMask;

  typedef enum logic {SAMPLE, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [StrapWidth-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]            sync_vld_q, sync_vld_d;
  logic [StrapWidth-1:0] cand_q, cand_d;
  logic                  cand_vld_q, cand_vld_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [StrapWidth-1:0] mode_q, mode_d;
  logic                  match;
  logic                  jtag_en;
  logic                  tdo_sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SAMPLE;
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync_vld_q <= '0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync_vld_q <= sync_vld_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
    end
  end

  // Synchroniser output counts only once both flops hold real pad samples, and the
  // first real sample always reloads the candidate, so lock timing never depends on reset values.
  assign match = cand_vld_q && (sync2_q == cand_q);

  always_comb begin
    sync1_d    = in_padring_i[StrapLsbIdx +: StrapWidth];
    sync2_d    = sync1_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    mode_d     = mode_q;

    if (sync_vld_q[1]) begin
      if (!match) begin
        cand_d     = sync2_q;
        cand_vld_d = 1'b1;
        cnt_d      = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    case (state_q)
      SAMPLE: begin
        if (sync_vld_q[1] && match && (cnt_q == CntMax)) begin
          state_d = LOCKED;
          mode_d  = (cand_q > MaxMode) ? '0 : cand_q;
        end
      end
      LOCKED: begin
        if (resample_i && !lock_i) begin
          state_d = SAMPLE;
          mode_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = SAMPLE;
    endcase
  end

  assign mode_o       = mode_q;
  assign mode_valid_o = (state_q == LOCKED);
  assign jtag_en      = (state_q == LOCKED) && (mode_q != '0);

  always_comb begin
    tap_tck_o   = '0;
    tap_tms_o   = '1;
    tap_tdi_o   = '0;
    tap_trst_no = '0;
    tdo_sel     = 1'b0;
    for (int k = 0; k < NumTaps; k++) begin
      if (jtag_en && (mode_q == StrapWidth'(k + 1))) begin
        tap_tck_o[k]   = in_padring_i[TckIdx];
        tap_tms_o[k]   = in_padring_i[TmsIdx];
        tap_tdi_o[k]   = in_padring_i[TdiIdx];
        tap_trst_no[k] = in_padring_i[TrstIdx];
        tdo_sel        = tap_tdo_i[k];
      end
    end

    out_padring_o = out_core_i;
    oe_padring_o  = oe_core_i;
    in_core_o     = in_padring_i;
    if (jtag_en) begin
      oe_padring_o  = (oe_core_i & ~AllMask) | TdoMask;
      out_padring_o = (out_core_i & ~AllMask) | (tdo_sel ? TdoMask : '0);
      in_core_o     = (in_padring_i & ~AllMask) | (TieOffValues & AllMask);
    end
  end

`ifdef JTAG_STRAP_MUX_SRST_EN
  assign jtag_srst_no = jtag_en ? in_padring_i[SrstIdx] : 1'b1;
`endif

endmodule

// File: tb/tb_jtag_strap_mux.sv
// Directed bench for jtag_strap_mux: a 3-TAP instance with non-zero tie-offs and a
// 2-TAP instance sharing the same pads (used for the out-of-range strap case).
module tb_jtag_strap_mux;

  localparam logic [46:0] TIE = 47'h9_0015;
  localparam int TCK = 0, TMS = 1, TDI = 2, TDO = 3, TRST = 4, SRST = 19;
`ifdef JTAG_STRAP_MUX_SRST_EN
  localparam logic [46:0] CLAIM = 47'h3_0017 | (47'd1 << SRST);
`else
  localparam logic [46:0] CLAIM = 47'h3_0017;
`endif
  localparam logic [46:0] TDOM = 47'd1 << TDO;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, lock, resample;
  logic [2:0]  tdo;
  logic [46:0] out_core, oe_core, in_pad;

  logic [1:0]  mode1;
  logic        mv1;
  logic [2:0]  tck1, tms1, tdi1, trstn1;
  logic [46:0] in_core1, out_pad1, oe_pad1;

  logic [1:0]  mode2;
  logic        mv2;
  logic [1:0]  tck2, tms2, tdi2, trstn2;
  logic [46:0] in_core2, out_pad2, oe_pad2;
`ifdef JTAG_STRAP_MUX_SRST_EN
  logic        srst1, srst2;
`endif

  jtag_strap_mux #(.NumTaps(3), .TieOffValues(TIE)) u_dut (
    .clk_i(clk), .rst_i(rst), .lock_i(lock), .resample_i(resample),
    .mode_o(mode1), .mode_valid_o(mv1),
    .tap_tck_o(tck1), .tap_tms_o(tms1), .tap_tdi_o(tdi1), .tap_trst_no(trstn1),
    .tap_tdo_i(tdo),
    .out_core_i(out_core), .oe_core_i(oe_core), .in_core_o(in_core1),
    .out_padring_o(out_pad1), .oe_padring_o(oe_pad1), .in_padring_i(in_pad)
`ifdef JTAG_STRAP_MUX_SRST_EN
    , .jtag_srst_no(srst1)
`endif
  );

  jtag_strap_mux #(.NumTaps(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .lock_i(lock), .resample_i(resample),
    .mode_o(mode2), .mode_valid_o(mv2),
    .tap_tck_o(tck2), .tap_tms_o(tms2), .tap_tdi_o(tdi2), .tap_trst_no(trstn2),
    .tap_tdo_i(tdo[1:0]),
    .out_core_i(out_core), .oe_core_i(oe_core), .in_core_o(in_core2),
    .out_padring_o(out_pad2), .oe_padring_o(oe_pad2), .in_padring_i(in_pad)
`ifdef JTAG_STRAP_MUX_SRST_EN
    , .jtag_srst_no(srst2)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_strap(input logic [1:0] v);
    in_pad[17:16] = v;
  endtask

  task automatic pulse_resample();
    resample = 1'b1;
    tick();
    resample = 1'b0;
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (!mv1 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 64'(mv1), 64'd1);
  endtask

  task automatic chk_passthru(input string tag);
    chk({tag, "_in"},  64'(in_core1), 64'(in_pad));
    chk({tag, "_out"}, 64'(out_pad1), 64'(out_core));
    chk({tag, "_oe"},  64'(oe_pad1),  64'(oe_core));
    chk({tag, "_tck"}, 64'(tck1), 64'd0);
    chk({tag, "_tms"}, 64'(tms1), 64'h7);
    chk({tag, "_rst"}, 64'(trstn1), 64'd0);
  endtask

  logic [46:0] exp_in, exp_out, exp_oe;

  initial begin
    rst = 1'b1; lock = 1'b0; resample = 1'b0; tdo = 3'b000;
    out_core = 47'h456_789A_BCDE;
    oe_core  = 47'h3A5_C3A5_C3A5;
    in_pad   = 47'h2F0_F0F0_F0E0;
    set_strap(2'b01);
    repeat (3) tick();

    // reset state while rst is still high
    chk("rst_mode", 64'(mode1), 64'd0);
    chk("rst_valid", 64'(mv1), 64'd0);
    chk("rst_tdi", 64'(tdi1), 64'd0);
    chk_passthru("rst");

    // release: lock expected on the 7th edge
    rst = 1'b0;
    for (int n = 1; n <= 6; n++) tick();
    chk("lock_edge6", 64'(mv1), 64'd0);
    tick();
    chk("lock_edge7", 64'(mv1), 64'd1);
    chk("lock_mode1", 64'(mode1), 64'd1);

    in_pad[TCK] = 1'b1; in_pad[TMS] = 1'b0; in_pad[TDI] = 1'b1; in_pad[TRST] = 1'b1;
    #1;
    chk("m1_tck_hi", 64'(tck1), 64'h1);
    chk("m1_tms", 64'(tms1), 64'h6);
    chk("m1_tdi", 64'(tdi1), 64'h1);
    chk("m1_trst", 64'(trstn1), 64'h1);
    in_pad[TCK] = 1'b0;
    #1;
    chk("m1_tck_lo", 64'(tck1), 64'h0);
    in_pad[TCK] = 1'b1;

    // glitchy straps never settle for 4 cycles
    pulse_resample();
    chk("rs_valid0", 64'(mv1), 64'd0);
    chk("rs_mode0", 64'(mode1), 64'd0);
    chk("rs_tck_idle", 64'(tck1), 64'd0);
    for (int i = 0; i < 10; i++) begin
      set_strap((i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      chk("glitch_a", 64'(mv1), 64'd0);
      tick();
      chk("glitch_b", 64'(mv1), 64'd0);
    end
    set_strap(2'b10);
    for (int n = 1; n <= 6; n++) tick();
    chk("glitch_edge6", 64'(mv1), 64'd0);
    tick();
    chk("glitch_edge7", 64'(mv1), 64'd1);
    chk("glitch_mode", 64'(mode1), 64'd2);
    chk("m2_tck", 64'(tck1), 64'h2);
    chk("dut2_mode2", 64'(mode2), 64'd2);

    // lifecycle lock: resample ignored
    lock = 1'b1;
    set_strap(2'b11);
    pulse_resample();
    repeat (10) tick();
    chk("lk_valid", 64'(mv1), 64'd1);
    chk("lk_mode", 64'(mode1), 64'd2);
    chk("lk_tck", 64'(tck1), 64'h2);
    lock = 1'b0;

    // mode 3 on the 3-TAP instance, out-of-range on the 2-TAP instance
    pulse_resample();
    chk("m3_drop", 64'(mv1), 64'd0);
    wait_lock("m3_relock");
    chk("m3_mode", 64'(mode1), 64'd3);
    chk("dut2_valid", 64'(mv2), 64'd1);
    chk("dut2_mode0", 64'(mode2), 64'd0);
    tdo = 3'b100;
    #1;
    exp_in  = (in_pad & ~(CLAIM | TDOM)) | (TIE & (CLAIM | TDOM));
    exp_oe  = (oe_core & ~(CLAIM | TDOM)) | TDOM;
    exp_out = (out_core & ~(CLAIM | TDOM)) | TDOM;
    chk("m3_in_core", 64'(in_core1), 64'(exp_in));
    chk("m3_oe_pad", 64'(oe_pad1), 64'(exp_oe));
    chk("m3_out_pad", 64'(out_pad1), 64'(exp_out));
    chk("m3_tck", 64'(tck1), 64'h4);
    chk("m3_trst", 64'(trstn1), 64'h4);
    tdo = 3'b011;
    #1;
    chk("m3_tdo_lo", 64'(out_pad1[TDO]), 64'd0);
    chk("dut2_in", 64'(in_core2), 64'(in_pad));
    chk("dut2_oe", 64'(oe_pad2), 64'(oe_core));
    chk("dut2_out", 64'(out_pad2), 64'(out_core));
    chk("dut2_tck", 64'(tck2), 64'd0);
    chk("dut2_trst", 64'(trstn2), 64'd0);
`ifdef JTAG_STRAP_MUX_SRST_EN
    chk("dut2_srst", 64'(srst2), 64'd1);
    in_pad[SRST] = 1'b0;
    #1;
    chk("m3_srst_lo", 64'(srst1), 64'd0);
    in_pad[SRST] = 1'b1;
    #1;
    chk("m3_srst_hi", 64'(srst1), 64'd1);
`endif

    // mode 1 then resample to functional mode 0
    set_strap(2'b01);
    pulse_resample();
    wait_lock("m1b_relock");
    chk("m1b_mode", 64'(mode1), 64'd1);
    set_strap(2'b00);
    pulse_resample();
    chk("m0_drop", 64'(mv1), 64'd0);
    chk_passthru("m0_idle");
    wait_lock("m0_relock");
    chk("m0_mode", 64'(mode1), 64'd0);
    chk_passthru("m0_lock");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
